// File: rtl/bubble_spawn_ctrl.sv
// Slot allocator and sequencer for a pool of bubble_move instances: seeds each level, turns splits into children.
// Optional: define BUBBLE_SPAWN_SCORE_EN to add a saturating 16-bit score output.
module bubble_spawn_ctrl #(
    parameter int N_SLOTS   = 8,
    parameter int INIT_SIZE = 3,
    parameter int INIT_X    = 100,
    parameter int INIT_Y    = 60
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  level_start,
    input  logic [N_SLOTS-1:0]    split,
    input  logic [11*N_SLOTS-1:0] slot_x,
    input  logic [11*N_SLOTS-1:0] slot_y,
    output logic [N_SLOTS-1:0]    start,
    output logic [N_SLOTS-1:0]    direction,
    output logic [3*N_SLOTS-1:0]  size,
    output logic [11*N_SLOTS-1:0] startTopX,
    output logic [11*N_SLOTS-1:0] startTopY,
    output logic [N_SLOTS-1:0]    active,
    output logic                  level_done,
    output logic                  overflow
`ifdef BUBBLE_SPAWN_SCORE_EN
    ,
    output logic [15:0]           score
`endif
);
    localparam int IW = $clog2(N_SLOTS);

    typedef enum logic [2:0] {IDLE, SEED, PICK, SPAWN_L, SPAWN_R} state_t;

    state_t             state_q, state_d;
    logic [N_SLOTS-1:0] pending_q, pending_d;
    logic [N_SLOTS-1:0] active_q, active_d;
    logic [N_SLOTS-1:0] dir_q, dir_d;
    logic [N_SLOTS-1:0] start_d;
    logic [N_SLOTS-1:0] cap_mask;
    logic               armed_q, armed_d;
    logic               overflow_q, overflow_d;
    logic               done_d;
    logic [IW-1:0]      sel_q, sel_d;
    logic [IW-1:0]      pend_idx, free_idx;
    logic               free_found;

    logic [2:0]  size_q [N_SLOTS];
    logic [2:0]  size_d [N_SLOTS];
    logic [10:0] x_q    [N_SLOTS];
    logic [10:0] x_d    [N_SLOTS];
    logic [10:0] y_q    [N_SLOTS];
    logic [10:0] y_d    [N_SLOTS];
    logic [2:0]  cap_size_q [N_SLOTS];
    logic [2:0]  cap_size_d [N_SLOTS];
    logic [10:0] cap_x_q    [N_SLOTS];
    logic [10:0] cap_x_d    [N_SLOTS];
    logic [10:0] cap_y_q    [N_SLOTS];
    logic [10:0] cap_y_d    [N_SLOTS];

`ifdef BUBBLE_SPAWN_SCORE_EN
    logic [15:0] score_q, score_d;
    logic [16:0] score_sum;
    assign score_sum = {1'b0, score_q} + 17'(4'd8 - {1'b0, cap_size_q[pend_idx]});
    assign score     = score_q;
`endif

    // Splits are discarded while a level restart is being taken.
    assign cap_mask = level_start ? '0 : (split & active_q);

    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) begin
            cap_size_d[i] = cap_mask[i] ? size_q[i] : cap_size_q[i];
            cap_x_d[i]    = cap_mask[i] ? slot_x[11*i +: 11] : cap_x_q[i];
            cap_y_d[i]    = cap_mask[i] ? slot_y[11*i +: 11] : cap_y_q[i];
        end
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        pend_idx   = '0;
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (pending_q[i]) pend_idx = IW'(i);
            if (!active_q[i] && !pending_q[i]) begin
                free_idx   = IW'(i);
                free_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        pending_d  = pending_q | cap_mask;
        active_d   = active_q & ~cap_mask;
        armed_d    = armed_q;
        overflow_d = overflow_q;
        start_d    = '0;
        dir_d      = dir_q;
        size_d     = size_q;
        x_d        = x_q;
        y_d        = y_q;
`ifdef BUBBLE_SPAWN_SCORE_EN
        score_d    = score_q;
`endif
        done_d = armed_q && (active_q == '0) && (pending_q == '0) && (state_q == IDLE);
        if (done_d) armed_d = 1'b0;

        if (level_start) begin
            state_d    = SEED;
            pending_d  = '0;
            active_d   = '0;
            overflow_d = 1'b0;
`ifdef BUBBLE_SPAWN_SCORE_EN
            score_d    = '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (pending_q != '0) state_d = PICK;
                SEED: begin
                    size_d[0]   = 3'(INIT_SIZE);
                    x_d[0]      = 11'(INIT_X);
                    y_d[0]      = 11'(INIT_Y);
                    dir_d[0]    = 1'b1;
                    start_d[0]  = 1'b1;
                    active_d[0] = 1'b1;
                    armed_d     = 1'b1;
                    state_d     = IDLE;
                end
                PICK: begin
                    sel_d               = pend_idx;
                    pending_d[pend_idx] = 1'b0;
`ifdef BUBBLE_SPAWN_SCORE_EN
                    score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
`endif
                    state_d = (cap_size_q[pend_idx] == 3'd0) ? IDLE : SPAWN_L;
                end
                SPAWN_L, SPAWN_R: begin
                    // The left child is already active by SPAWN_R, so it is excluded there.
                    if (free_found) begin
                        size_d[free_idx]   = cap_size_q[sel_q] - 3'd1;
                        x_d[free_idx]      = cap_x_q[sel_q];
                        y_d[free_idx]      = cap_y_q[sel_q];
                        dir_d[free_idx]    = (state_q == SPAWN_R);
                        start_d[free_idx]  = 1'b1;
                        active_d[free_idx] = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                    state_d = (state_q == SPAWN_L) ? SPAWN_R : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            pending_q  <= '0;
            active_q   <= '0;
            armed_q    <= 1'b0;
            overflow_q <= 1'b0;
            dir_q      <= '0;
`ifdef BUBBLE_SPAWN_SCORE_EN
            score_q    <= '0;
`endif
            for (int i = 0; i < N_SLOTS; i++) begin
                size_q[i]     <= '0;
                x_q[i]        <= '0;
                y_q[i]        <= '0;
                cap_size_q[i] <= '0;
                cap_x_q[i]    <= '0;
                cap_y_q[i]    <= '0;
            end
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            pending_q  <= pending_d;
            active_q   <= active_d;
            armed_q    <= armed_d;
            overflow_q <= overflow_d;
            dir_q      <= dir_d;
`ifdef BUBBLE_SPAWN_SCORE_EN
            score_q    <= score_d;
`endif
            size_q     <= size_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cap_size_q <= cap_size_d;
            cap_x_q    <= cap_x_d;
            cap_y_q    <= cap_y_d;
        end
    end

    // Per-slot parameters become visible in the same cycle as their start pulse.
    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_out
        assign size[3*gi +: 3]       = size_d[gi];
        assign startTopX[11*gi +: 11] = x_d[gi];
        assign startTopY[11*gi +: 11] = y_d[gi];
    end

    assign start      = start_d;
    assign direction  = dir_d;
    assign active     = active_q;
    assign overflow   = overflow_q;
    assign level_done = done_d;

endmodule

// File: tb/tb_bubble_spawn_ctrl.sv
// Randomized scoreboard bench for bubble_spawn_ctrl against a schedule-based reference model.
module tb_bubble_spawn_ctrl;
    localparam int N    = 8;
    localparam int ISZ  = 4;   // larger seed so the pool can run out of slots
    localparam int IX   = 100;
    localparam int IY   = 60;
    localparam int NCYC = 6000;

    logic            clk = 1'b0;
    logic            resetN;
    logic            level_start;
    logic [N-1:0]    split;
    logic [11*N-1:0] slot_x, slot_y;
    logic [N-1:0]    start, direction, active;
    logic [3*N-1:0]  size;
    logic [11*N-1:0] startTopX, startTopY;
    logic            level_done, overflow;
`ifdef BUBBLE_SPAWN_SCORE_EN
    logic [15:0]     score;
`endif

    bubble_spawn_ctrl #(.N_SLOTS(N), .INIT_SIZE(ISZ), .INIT_X(IX), .INIT_Y(IY)) dut (
        .clk(clk), .resetN(resetN), .level_start(level_start), .split(split),
        .slot_x(slot_x), .slot_y(slot_y), .start(start), .direction(direction),
        .size(size), .startTopX(startTopX), .startTopY(startTopY), .active(active),
        .level_done(level_done), .overflow(overflow)
`ifdef BUBBLE_SPAWN_SCORE_EN
        , .score(score)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          slot;
        logic [2:0]  sz;
        logic [10:0] x;
        logic [10:0] y;
        logic        d;
    } spawn_t;

    typedef struct {
        int              cyc;
        logic [N-1:0]    act;
        logic            ovf;
        logic            ld;
        logic [N-1:0]    dir;
        logic [3*N-1:0]  sz;
        logic [11*N-1:0] x;
        logic [11*N-1:0] y;
        int              sc;
    } stat_t;

    spawn_t sp_q[$];
    stat_t  st_q[$];
    int     chk_cnt = 0;
    int     err_cnt = 0;

    // Reference model: per-slot pool contents plus absolute-cycle schedule of controller actions.
    logic [N-1:0] m_act = '0, m_pend = '0, m_dir = '0;
    logic [2:0]   m_sz [N];
    logic [10:0]  m_x [N], m_y [N];
    logic [2:0]   m_csz [N];
    logic [10:0]  m_cx [N], m_cy [N];
    logic         m_armed = 1'b0, m_ovf = 1'b0;
    int m_seed_at = -1, m_pick_at = -1, m_spl_at = -1, m_spr_at = -1, m_free_at = 0;
    int m_job = 0, m_left = -1, m_score = 0;

    task automatic chk(input string nm, input int cyc, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    task automatic give(input int c, input int f, input logic [2:0] sz, input logic [10:0] x,
                        input logic [10:0] y, input logic d);
        m_sz[f]  = sz;
        m_x[f]   = x;
        m_y[f]   = y;
        m_dir[f] = d;
        sp_q.push_back('{cyc: c, slot: f, sz: sz, x: x, y: y, d: d});
    endtask

    task automatic model_step(input int c, input logic ls, input logic [N-1:0] sp,
                              input logic [11*N-1:0] sx, input logic [11*N-1:0] sy);
        logic [N-1:0] a0, p0, cap, set_a, clr_p;
        stat_t s;
        bit    idle;
        int    f;
        a0 = m_act;
        p0 = m_pend;
        s.cyc = c;
        s.act = a0;
        s.ovf = m_ovf;
        s.sc  = m_score;
        idle  = (c >= m_free_at) && (c != m_pick_at) && (c != m_seed_at);
        s.ld  = m_armed && (a0 == '0) && (p0 == '0) && idle;
        if (s.ld) m_armed = 1'b0;
        if (ls) begin
            m_act = '0; m_pend = '0; m_ovf = 1'b0; m_score = 0;
            m_seed_at = c + 1; m_pick_at = -1; m_spl_at = -1; m_spr_at = -1; m_free_at = c + 2;
        end else begin
            cap = sp & a0; set_a = '0; clr_p = '0;
            if (c == m_seed_at) begin
                give(c, 0, 3'(ISZ), 11'(IX), 11'(IY), 1'b1);
                set_a[0] = 1'b1;
                m_armed  = 1'b1;
            end else if (c == m_pick_at) begin
                m_job = -1;
                for (int i = 0; i < N; i++) if (p0[i] && m_job < 0) m_job = i;
                if (m_job < 0) m_job = 0;
                clr_p[m_job] = 1'b1;
                m_score = m_score + 8 - int'(m_csz[m_job]);
                if (m_score > 65535) m_score = 65535;
                if (m_csz[m_job] == 3'd0) m_free_at = c + 1;
                else begin m_spl_at = c + 1; m_spr_at = c + 2; m_free_at = c + 3; end
            end else if (c == m_spl_at || c == m_spr_at) begin
                f = -1;
                for (int i = 0; i < N; i++)
                    if (f < 0 && !a0[i] && !p0[i] && !(c == m_spr_at && i == m_left)) f = i;
                if (c == m_spl_at) m_left = f;
                if (f >= 0) begin
                    give(c, f, 3'(m_csz[m_job] - 3'd1), m_cx[m_job], m_cy[m_job], c == m_spr_at);
                    set_a[f] = 1'b1;
                end else m_ovf = 1'b1;
            end else if (idle && p0 != '0) begin
                m_pick_at = c + 1;
                m_free_at = c + 2;
            end
            for (int i = 0; i < N; i++) if (cap[i]) begin
                m_csz[i] = m_sz[i];
                m_cx[i]  = sx[11*i +: 11];
                m_cy[i]  = sy[11*i +: 11];
            end
            m_act  = (a0 & ~cap) | set_a;
            m_pend = (p0 | cap) & ~clr_p;
        end
        s.dir = m_dir;
        for (int i = 0; i < N; i++) begin
            s.sz[3*i +: 3]  = m_sz[i];
            s.x[11*i +: 11] = m_x[i];
            s.y[11*i +: 11] = m_y[i];
        end
        st_q.push_back(s);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_sz[i] = '0; m_x[i] = '0; m_y[i] = '0;
            m_csz[i] = '0; m_cx[i] = '0; m_cy[i] = '0;
        end
    end

    // Monitor: compares every cycle's outputs and pops a spawn record whenever a start is due.
    initial begin : monitor
        stat_t        s;
        spawn_t       e;
        logic [N-1:0] exp_start;
        forever begin
            @(negedge clk);
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                exp_start = '0;
                if (start != '0 || (sp_q.size() > 0 && sp_q[0].cyc == s.cyc)) begin
                    if (sp_q.size() > 0 && sp_q[0].cyc == s.cyc) begin
                        e = sp_q.pop_front();
                        exp_start[e.slot] = 1'b1;
                        $display("cyc=%0d spawn slot=%0d size=%0d x=%0d y=%0d dir=%0d", s.cyc, e.slot, e.sz, e.x, e.y, e.d);
                        chk("spawn_size", s.cyc, size[3*e.slot +: 3], e.sz);
                        chk("spawn_x", s.cyc, startTopX[11*e.slot +: 11], e.x);
                        chk("spawn_y", s.cyc, startTopY[11*e.slot +: 11], e.y);
                        chk("spawn_dir", s.cyc, direction[e.slot], e.d);
                    end
                end
                chk("start", s.cyc, start, exp_start);
                chk("active", s.cyc, active, s.act);
                chk("overflow", s.cyc, overflow, s.ovf);
                chk("level_done", s.cyc, level_done, s.ld);
                chk("direction", s.cyc, direction, s.dir);
                chk("size", s.cyc, size, s.sz);
                chk("startTopX", s.cyc, startTopX, s.x);
                chk("startTopY", s.cyc, startTopY, s.y);
`ifdef BUBBLE_SPAWN_SCORE_EN
                chk("score", s.cyc, score, s.sc);
`endif
            end
        end
    end

    initial begin : driver
        logic            ls;
        logic [N-1:0]    sp;
        logic [11*N-1:0] sx, sy;
        resetN = 1'b0; level_start = 1'b0; split = '0; slot_x = '0; slot_y = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start", 0, start, 0);
        chk("rst_direction", 0, direction, 0);
        chk("rst_size", 0, size, 0);
        chk("rst_x", 0, startTopX, 0);
        chk("rst_y", 0, startTopY, 0);
        chk("rst_active", 0, active, 0);
        chk("rst_level_done", 0, level_done, 0);
        chk("rst_overflow", 0, overflow, 0);
`ifdef BUBBLE_SPAWN_SCORE_EN
        chk("rst_score", 0, score, 0);
`endif
        resetN = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            ls = 1'b0;
            if (c == 2) ls = 1'b1;
            else if (c > 2) begin
                if (m_spl_at == c && $urandom_range(0, 7) == 0) ls = 1'b1;
                else if (m_act == '0 && m_pend == '0 && m_seed_at < c && $urandom_range(0, 5) == 0) ls = 1'b1;
                else if ($urandom_range(0, 399) == 0) ls = 1'b1;
            end
            sp = N'($urandom & $urandom & $urandom & $urandom);
            for (int i = 0; i < N; i++) begin
                sx[11*i +: 11] = 11'($urandom);
                sy[11*i +: 11] = 11'($urandom);
            end
            level_start = ls;
            split       = sp;
            slot_x      = sx;
            slot_y      = sy;
            model_step(c, ls, sp, sx, sy);
        end
        @(posedge clk);
        #1;
        level_start = 1'b0;
        split       = '0;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end
endmodule
